// File: rtl/fsr_contact_filter.sv
// fsr_contact_filter: scans eight FSR channels each tick, IIR-filters them and
// debounces a hysteretic contact flag per channel.
module fsr_contact_filter #(
  parameter int          SAMPLE_DIV = 50000,
  parameter int          SHIFT      = 2,
  parameter logic [11:0] TH_ON      = 12'h3F0,
  parameter logic [11:0] TH_OFF     = 12'h3B0,
  parameter int          DEBOUNCE   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_ch0,
  input  logic [11:0] i_ch1,
  input  logic [11:0] i_ch2,
  input  logic [11:0] i_ch3,
  input  logic [11:0] i_ch4,
  input  logic [11:0] i_ch5,
  input  logic [11:0] i_ch6,
  input  logic [11:0] i_ch7,
  input  logic [2:0]  i_filt_sel,
  output logic [11:0] o_filt_data,
  output logic [7:0]  o_contact,
  output logic        o_scan_done
);
  localparam int PW = $clog2(SAMPLE_DIV);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t              r_state, w_next;
  logic [PW-1:0]       r_pre;
  logic [2:0]          r_idx;
  logic [11:0]         r_snap [8];
  logic [11:0]         r_filt [8];
  logic [3:0]          r_cnt [8];
  logic [7:0]          r_contact;
  logic                r_done, r_primed;
  logic [11:0]         w_ch [8];
  logic                w_tick, w_qual, w_toggle;
  logic signed [12:0]  w_d, w_step, w_sum;
  logic [11:0]         w_fnew;
  logic [3:0]          w_inc;
  assign w_ch[0] = i_ch0;
  assign w_ch[1] = i_ch1;
  assign w_ch[2] = i_ch2;
  assign w_ch[3] = i_ch3;
  assign w_ch[4] = i_ch4;
  assign w_ch[5] = i_ch5;
  assign w_ch[6] = i_ch6;
  assign w_ch[7] = i_ch7;
  assign w_tick   = r_pre == PW'(SAMPLE_DIV - 1);
  assign w_d      = {1'b0, r_snap[r_idx]} - {1'b0, r_filt[r_idx]};
  assign w_step   = w_d >>> SHIFT;
  assign w_sum    = $signed({1'b0, r_filt[r_idx]}) + w_step;
  // the sum always lands in 0..4095; the sign check only keeps the read total
  assign w_fnew   = !r_primed ? r_snap[r_idx] : w_sum[12] ? 12'h000 : w_sum[11:0];
  assign w_qual   = r_contact[r_idx] ? w_fnew <= TH_OFF : w_fnew >= TH_ON;
  assign w_inc    = r_cnt[r_idx] + 4'd1;
  assign w_toggle = w_qual && w_inc == 4'(DEBOUNCE);
  assign o_filt_data = r_filt[i_filt_sel];
  assign o_contact   = r_contact;
  assign o_scan_done = r_done;
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE ? (w_tick ? SCAN : IDLE) :
             r_state == SCAN ? (r_idx == 3'd7 ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre     <= '0;
      r_idx     <= '0;
      r_contact <= '0;
      r_done    <= 1'b0;
      r_primed  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_snap[i] <= '0;
        r_filt[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_pre  <= w_tick ? '0 : r_pre + 1'b1;
      r_done <= r_state == SCAN && r_idx == 3'd7;
      if (r_state == IDLE && w_tick) begin
        r_snap <= w_ch;
        r_idx  <= '0;
      end
      if (r_state == SCAN) begin
        r_idx         <= r_idx + 3'd1;
        r_filt[r_idx] <= w_fnew;
        r_cnt[r_idx]  <= w_qual && !w_toggle ? w_inc : 4'd0;
        if (w_toggle) r_contact[r_idx] <= ~r_contact[r_idx];
        if (r_idx == 3'd7) r_primed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fsr_contact_filter.sv
// tb_fsr_contact_filter: table of per-scan vectors checked against a behavioural
// scoreboard model, plus hand sequences for mid-scan reset and late input changes.
module tb_fsr_contact_filter;
  localparam int          SD   = 16;
  localparam int          SH   = 2;
  localparam int          DEB  = 3;
  localparam logic [11:0] TON  = 12'h3F0;
  localparam logic [11:0] TOFF = 12'h3B0;
  typedef logic [7:0][11:0] chv_t;
  typedef struct {
    bit          rst;
    chv_t        ch;
    bit          late_en;
    chv_t        late;
    logic [2:0]  sel;
    logic [11:0] ef;
    logic [7:0]  ec;
  } vec_t;
  typedef struct {
    chv_t       f;
    logic [7:0] c;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  chv_t        ch  = '0;
  logic [2:0]  sel = '0;
  logic [11:0] fdata;
  logic [7:0]  contact;
  logic        done;
  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  vec_t        vt[21];
  logic [11:0] m_filt [8];
  int          m_cnt [8];
  logic [7:0]  m_con;
  bit          m_primed;
  fsr_contact_filter #(.SAMPLE_DIV(SD), .SHIFT(SH), .TH_ON(TON), .TH_OFF(TOFF), .DEBOUNCE(DEB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ch0(ch[0]), .i_ch1(ch[1]), .i_ch2(ch[2]), .i_ch3(ch[3]),
    .i_ch4(ch[4]), .i_ch5(ch[5]), .i_ch6(ch[6]), .i_ch7(ch[7]),
    .i_filt_sel(sel), .o_filt_data(fdata), .o_contact(contact), .o_scan_done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask
  function automatic chv_t v1(input int i, input logic [11:0] v);
    chv_t r = '0;
    r[i] = v;
    return r;
  endfunction
  function automatic vec_t mk(input bit r, input chv_t c, input bit le, input chv_t l,
                              input logic [2:0] s, input logic [11:0] ef, input logic [7:0] ec);
    vec_t v;
    v.rst = r; v.ch = c; v.late_en = le; v.late = l; v.sel = s; v.ef = ef; v.ec = ec;
    return v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_filt[i] = '0;
      m_cnt[i]  = 0;
    end
    m_con    = '0;
    m_primed = 0;
    sb.delete();
  endtask
  // floor division by 2^SH done with integer arithmetic, independent of any shifter
  task automatic model_scan(input chv_t c);
    exp_t e;
    int   p = 1 << SH;
    for (int i = 0; i < 8; i++) begin
      int  d, step;
      logic [11:0] nf;
      bit  q;
      d    = int'(c[i]) - int'(m_filt[i]);
      step = d >= 0 ? d / p : -((-d + p - 1) / p);
      nf   = m_primed ? 12'(int'(m_filt[i]) + step) : c[i];
      q    = m_con[i] ? (nf <= TOFF) : (nf >= TON);
      if (q) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_con[i] = ~m_con[i];
          m_cnt[i] = 0;
        end
      end else m_cnt[i] = 0;
      m_filt[i] = nf;
      e.f[i]    = nf;
    end
    m_primed = 1;
    e.c = m_con;
    sb.push_back(e);
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    bit   got = 0;
    if (v.rst) begin
      rst = 1'b1;
      ch  = v.ch;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
    end else ch = v.ch;
    model_scan(v.ch);
    if (v.late_en) begin
      repeat (8) @(posedge clk);
      #1 ch = v.late;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1 got = done;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL scan_done_timeout v%0d: got 0 required 1", idx);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check($sformatf("v%0d contact", idx), {4'h0, contact}, {4'h0, e.c});
    check($sformatf("v%0d contact_tbl", idx), {4'h0, contact}, {4'h0, v.ec});
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      check($sformatf("v%0d filt%0d", idx, s), fdata, e.f[s]);
      if (3'(s) == v.sel) check($sformatf("v%0d filt_tbl%0d", idx, s), fdata, v.ef);
    end
  endtask
  initial begin
    bit seen;
    vt[0]  = mk(1, v1(3, 12'h800), 0, '0, 3'd3, 12'h800, 8'h00);
    vt[1]  = mk(0, v1(0, 12'h400), 0, '0, 3'd0, 12'h100, 8'h00);
    vt[2]  = mk(0, v1(0, 12'h400), 0, '0, 3'd0, 12'h1C0, 8'h08);
    vt[3]  = mk(0, v1(0, 12'h400), 0, '0, 3'd0, 12'h250, 8'h08);
    vt[4]  = mk(0, v1(0, 12'h400), 0, '0, 3'd0, 12'h2BC, 8'h08);
    vt[5]  = mk(1, v1(5, 12'hFFF), 0, '0, 3'd5, 12'hFFF, 8'h00);
    vt[6]  = mk(0, v1(5, 12'h3F0), 0, '0, 3'd5, 12'hCFB, 8'h00);
    vt[7]  = mk(0, v1(5, 12'h3F0), 0, '0, 3'd5, 12'hAB8, 8'h20);
    vt[8]  = mk(0, v1(2, 12'h900), 0, '0, 3'd2, 12'h900, 8'h00);
    vt[9]  = mk(1, v1(1, 12'h460), 0, '0, 3'd1, 12'h460, 8'h00);
    vt[10] = mk(0, v1(1, 12'h460), 0, '0, 3'd1, 12'h460, 8'h00);
    vt[11] = mk(0, v1(1, 12'h460), 0, '0, 3'd1, 12'h460, 8'h02);
    vt[12] = mk(0, v1(1, 12'h160), 0, '0, 3'd1, 12'h3A0, 8'h02);
    vt[13] = mk(0, v1(1, 12'h460), 0, '0, 3'd1, 12'h3D0, 8'h02);
    vt[14] = mk(0, v1(1, 12'h310), 0, '0, 3'd1, 12'h3A0, 8'h02);
    vt[15] = mk(0, v1(1, 12'h460), 0, '0, 3'd1, 12'h3D0, 8'h02);
    vt[16] = mk(0, v1(1, 12'h310), 0, '0, 3'd1, 12'h3A0, 8'h02);
    vt[17] = mk(0, v1(1, 12'h3A0), 0, '0, 3'd1, 12'h3A0, 8'h02);
    vt[18] = mk(0, v1(1, 12'h3A0), 0, '0, 3'd1, 12'h3A0, 8'h00);
    vt[19] = mk(0, v1(6, 12'h500), 1, v1(6, 12'hFFF), 3'd6, 12'h140, 8'h00);
    vt[20] = mk(0, v1(6, 12'hFFF), 0, '0, 3'd6, 12'h4EF, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset contact", {4'h0, contact}, 12'h000);
    check("reset scan_done", {11'h0, done}, 12'h000);
    check("reset filt", fdata, 12'h000);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) run_vec(vt[i], i);
    // reset lands while channel 3 of the next scan is being processed
    ch = v1(2, 12'h900);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    sel = 3'd5;
    #1;
    check("midscan_rst contact", {4'h0, contact}, 12'h000);
    check("midscan_rst scan_done", {11'h0, done}, 12'h000);
    check("midscan_rst filt5", fdata, 12'h000);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) seen = 1;
    end
    check("midscan_rst no_partial_done", {11'h0, seen}, 12'h000);
    for (int i = 8; i < 21; i++) run_vec(vt[i], i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
